// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int DUTY_W_DEF = 10;
  localparam int CLK_HZ     = 100_000_000;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compare arithmetic, shadow/active compare and the registered comparator.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              apply,
  input  logic              run,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  logic [CNT_W+DUTY_W-1:0] prod;
  logic [CNT_W-1:0]        cmp_next;
  logic [DUTY_W-1:0]       unused_frac;
  logic [CNT_W-1:0]        cmp_shadow;
  logic [CNT_W-1:0]        cmp_active;

  // Full-width product, then drop the fractional DUTY_W bits.
  assign prod = {{DUTY_W{1'b0}}, cfg_period} * {{CNT_W{1'b0}}, duty};
  assign {cmp_next, unused_frac} = prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_shadow <= '0;
      cmp_active <= '0;
      pwm        <= 1'b0;
    end else begin
      if (capture) cmp_shadow <= cmp_next;
      if (apply)   cmp_active <= cmp_shadow;
      pwm <= run && (cnt < cmp_active);
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared period counter and glitch-free config update.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
//
// cfg_state   | meaning
// CFG_IDLE    | no shadow config waiting; cfg_ready high
// CFG_PENDING | shadow holds a config to be applied at the next wrap (or at once when idle)
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CH     = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [CH*DUTY_W-1:0] cfg_duty,
  output logic [CH-1:0]        pwm,
  output logic                 period_tick
);

  cfg_state_t       cfg_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_period;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] last;
  logic             run;
  logic             wrap;
  logic             capture;
  logic             apply;

  assign last    = active_period - CNT_W'(1);
  assign run     = en && (active_period >= CNT_W'(2));
  assign capture = cfg_valid && cfg_ready;
  // A stopped counter has no boundary to wait for, so apply straight away.
  assign apply   = (cfg_state == CFG_PENDING) && (wrap || !run);

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_down;
  assign wrap = run && dir_down && (cnt == '0);
`else
  assign wrap = run && (cnt == last);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      active_period <= '0;
      shadow_period <= '0;
      cfg_state     <= CFG_IDLE;
      cfg_ready     <= 1'b1;
      period_tick   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down      <= 1'b0;
`endif
    end else begin
      period_tick <= wrap;

`ifdef PWM_CENTER_ALIGN_EN
      // Endpoints are held one cycle each while the direction flips.
      if (!run) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (!dir_down) begin
        if (cnt == last) dir_down <= 1'b1;
        else             cnt      <= cnt + CNT_W'(1);
      end else begin
        if (cnt == '0) dir_down <= 1'b0;
        else           cnt      <= cnt - CNT_W'(1);
      end
`else
      if (!run || wrap) cnt <= '0;
      else              cnt <= cnt + CNT_W'(1);
`endif

      case (cfg_state)
        CFG_IDLE: begin
          if (capture) begin
            shadow_period <= cfg_period;
            cfg_state     <= CFG_PENDING;
            cfg_ready     <= 1'b0;
          end
        end
        CFG_PENDING: begin
          if (apply) begin
            active_period <= shadow_period;
            cfg_state     <= CFG_IDLE;
            cfg_ready     <= 1'b1;
          end
        end
        default: begin
          cfg_state <= CFG_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W),
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .apply     (apply),
      .run       (run),
      .cnt       (cnt),
      .cfg_period(cfg_period),
      .duty      (cfg_duty[i*DUTY_W +: DUTY_W]),
      .pwm       (pwm[i])
    );
  end

endmodule
